pc_next_unit: RTL and testbench

Parametrised program-counter unit for the multi-cycle CPU. It holds the architectural PC register and computes PC+4. During the decode state it latches the branch, jump and jump-register targets. In a later state it commits one of them on command from the control FSM, with a taken/not-taken condition. It adds target-alignment checking and, optionally, an exception/return path with an EPC register.

---
 rtl/pc_next_unit.sv | 137 +++++++++++++
 tb/tb_pc_next_unit.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pc_next_unit.sv
// pc_next_unit: architectural PC register with next-PC selection for the
// multi-cycle CPU. Branch, jump and jr targets are latched during decode
// (tgt_ld) and one of them is committed later on pc_wr. Commits to a target
// that is not word aligned are rejected and flagged on misalign.
//
// Optional feature macro: PC_NEXT_UNIT_EXC_EN
//   When defined, adds exc_req/eret inputs and the epc output. Exceptions and
//   misaligned commits save pc into epc and vector to EXC_VECTOR; eret
//   restores pc from epc.
//
// Ports:
//   clk, rst_n   clock (rising edge), asynchronous active-low reset
//   tgt_ld       latch branch/jump/jr targets from instr, rpc and pc
//   instr        current instruction word
//   rpc          register-file value used as the jr target
//   pc_wr        commit a new PC this cycle
//   pc_sel       00 sequential, 01 branch, 10 jump, 11 jr
//   br_taken     branch condition, only meaningful for pc_sel=01
//   pc           current PC (registered)
//   pc_plus4     pc+4 (combinational, wraps modulo 2^WIDTH)
//   bpc_q/jpc_q/jrpc_q  latched targets (registered)
//   misalign     one-cycle pulse after a rejected misaligned commit
//   exc_req/eret/epc    exception path (PC_NEXT_UNIT_EXC_EN only)
module pc_next_unit #(
    parameter int unsigned WIDTH      = 32,
    parameter logic [31:0] RESET_PC   = 32'h0000_3000,
    parameter logic [31:0] EXC_VECTOR = 32'h0000_4180
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             tgt_ld,
    input  logic [31:0]      instr,
    input  logic [WIDTH-1:0] rpc,
    input  logic             pc_wr,
    input  logic [1:0]       pc_sel,
    input  logic             br_taken,
`ifdef PC_NEXT_UNIT_EXC_EN
    input  logic             exc_req,
    input  logic             eret,
    output logic [WIDTH-1:0] epc,
`endif
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus4,
    output logic [WIDTH-1:0] bpc_q,
    output logic [WIDTH-1:0] jpc_q,
    output logic [WIDTH-1:0] jrpc_q,
    output logic             misalign
);

    localparam logic [1:0] SEL_SEQ = 2'b00;
    localparam logic [1:0] SEL_BR  = 2'b01;
    localparam logic [1:0] SEL_J   = 2'b10;

    localparam logic [WIDTH-1:0] RST_PC = WIDTH'(RESET_PC);
`ifdef PC_NEXT_UNIT_EXC_EN
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);
`else
    localparam logic [WIDTH-1:0] unused_exc_pc = WIDTH'(EXC_VECTOR);
`endif

    logic [WIDTH-1:0] br_off;
    logic [WIDTH-1:0] br_tgt;
    logic [WIDTH-1:0] j_tgt;
    logic [WIDTH-1:0] next_pc;
    logic             reject;
    logic [5:0]       unused_instr;

    assign unused_instr = instr[31:26];

    // Sequential successor, wraps at 2^WIDTH.
    assign pc_plus4 = pc + WIDTH'(4);

    // Branch offset: sign-extended 16-bit word offset scaled to bytes.
    assign br_off = {{(WIDTH-18){instr[15]}}, instr[15:0], 2'b00};
    assign br_tgt = pc_plus4 + br_off;
    assign j_tgt  = {pc_plus4[WIDTH-1:28], instr[25:0], 2'b00};

    // Next-PC mux uses the targets latched before this cycle.
    always_comb begin
        next_pc = pc_plus4;
        case (pc_sel)
            SEL_SEQ: next_pc = pc_plus4;
            SEL_BR:  next_pc = br_taken ? bpc_q : pc_plus4;
            SEL_J:   next_pc = jpc_q;
            default: next_pc = jrpc_q;
        endcase
    end

    assign reject = pc_wr && (next_pc[1:0] != 2'b00);

    // Target latches, loaded in decode.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bpc_q  <= '0;
            jpc_q  <= '0;
            jrpc_q <= '0;
        end else if (tgt_ld) begin
            bpc_q  <= br_tgt;
            jpc_q  <= j_tgt;
            jrpc_q <= rpc;
        end
    end

    // PC register, misalign pulse and (optionally) EPC.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc       <= RST_PC;
            misalign <= 1'b0;
`ifdef PC_NEXT_UNIT_EXC_EN
            epc      <= '0;
`endif
        end else begin
            misalign <= 1'b0;
`ifdef PC_NEXT_UNIT_EXC_EN
            if (exc_req) begin
                epc <= pc;
                pc  <= EXC_PC;
            end else if (eret) begin
                pc <= epc;
            end else if (reject) begin
                epc      <= pc;
                pc       <= EXC_PC;
                misalign <= 1'b1;
            end else if (pc_wr) begin
                pc <= next_pc;
            end
`else
            if (reject) begin
                misalign <= 1'b1;
            end else if (pc_wr) begin
                pc <= next_pc;
            end
`endif
        end
    end

endmodule

// File: tb/tb_pc_next_unit.sv
// tb_pc_next_unit: directed plus pseudo-random bench for pc_next_unit.
// Each step drives inputs on the falling edge, pushes the reference model's
// expected state into a scoreboard queue, and pops/compares it on the next
// falling edge after the DUT has clocked. Builds with or without
// PC_NEXT_UNIT_EXC_EN.
module tb_pc_next_unit;

    localparam int unsigned W = 32;
    localparam logic [W-1:0] RST_PC = 32'h0000_3000;
    localparam logic [W-1:0] EXC_PC = 32'h0000_4180;

    typedef struct {
        string        tag;
        logic [W-1:0] pc;
        logic [W-1:0] plus4;
        logic [W-1:0] bpc;
        logic [W-1:0] jpc;
        logic [W-1:0] jrpc;
        logic [W-1:0] epc;
        logic         mis;
    } exp_t;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         tgt_ld;
    logic [31:0]  instr;
    logic [W-1:0] rpc;
    logic         pc_wr;
    logic [1:0]   pc_sel;
    logic         br_taken;
    logic [W-1:0] pc;
    logic [W-1:0] pc_plus4;
    logic [W-1:0] bpc_q;
    logic [W-1:0] jpc_q;
    logic [W-1:0] jrpc_q;
    logic         misalign;
`ifdef PC_NEXT_UNIT_EXC_EN
    logic         exc_req;
    logic         eret;
    logic [W-1:0] epc;
`endif

    int errors = 0;
    int checks = 0;
    exp_t sb[$];

    // Reference model state.
    logic [W-1:0] m_pc, m_bpc, m_jpc, m_jrpc, m_epc;
    logic         m_mis;

    pc_next_unit #(
        .WIDTH(W),
        .RESET_PC(32'h0000_3000),
        .EXC_VECTOR(32'h0000_4180)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .tgt_ld(tgt_ld),
        .instr(instr),
        .rpc(rpc),
        .pc_wr(pc_wr),
        .pc_sel(pc_sel),
        .br_taken(br_taken),
`ifdef PC_NEXT_UNIT_EXC_EN
        .exc_req(exc_req),
        .eret(eret),
        .epc(epc),
`endif
        .pc(pc),
        .pc_plus4(pc_plus4),
        .bpc_q(bpc_q),
        .jpc_q(jpc_q),
        .jrpc_q(jrpc_q),
        .misalign(misalign)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic push_model(input string tag);
        exp_t e;
        e.tag   = tag;
        e.pc    = m_pc;
        e.plus4 = m_pc + W'(4);
        e.bpc   = m_bpc;
        e.jpc   = m_jpc;
        e.jrpc  = m_jrpc;
        e.epc   = m_epc;
        e.mis   = m_mis;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_empty observed=0 expected=1");
            return;
        end
        e = sb.pop_front();
        chk({e.tag, "_pc"}, pc, e.pc);
        chk({e.tag, "_pc_plus4"}, pc_plus4, e.plus4);
        chk({e.tag, "_bpc"}, bpc_q, e.bpc);
        chk({e.tag, "_jpc"}, jpc_q, e.jpc);
        chk({e.tag, "_jrpc"}, jrpc_q, e.jrpc);
        chk({e.tag, "_misalign"}, W'(misalign), W'(e.mis));
`ifdef PC_NEXT_UNIT_EXC_EN
        chk({e.tag, "_epc"}, epc, e.epc);
`endif
    endtask

    task automatic model_reset();
        m_pc   = RST_PC;
        m_bpc  = '0;
        m_jpc  = '0;
        m_jrpc = '0;
        m_epc  = '0;
        m_mis  = 1'b0;
    endtask

    // One clocked step: drive, update model, push expectation, compare after edge.
    task automatic step(input string tag, input logic t_ld, input logic [31:0] ins,
                        input logic [W-1:0] r, input logic wr, input logic [1:0] sel,
                        input logic bt, input logic exc, input logic er);
        logic [W-1:0] p4;
        logic [W-1:0] nxt;
        logic         rej;
        tgt_ld   = t_ld;
        instr    = ins;
        rpc      = r;
        pc_wr    = wr;
        pc_sel   = sel;
        br_taken = bt;
`ifdef PC_NEXT_UNIT_EXC_EN
        exc_req  = exc;
        eret     = er;
`else
        if (exc || er) $fatal(1, "FAIL %s exception stimulus in build without exception path", tag);
`endif
        p4 = m_pc + W'(4);
        case (sel)
            2'b00:   nxt = p4;
            2'b01:   nxt = bt ? m_bpc : p4;
            2'b10:   nxt = m_jpc;
            default: nxt = m_jrpc;
        endcase
        rej   = wr && (nxt[1:0] != 2'b00);
        m_mis = 1'b0;
        if (t_ld) begin
            m_bpc  = p4 + {{(W-18){ins[15]}}, ins[15:0], 2'b00};
            m_jpc  = {p4[W-1:28], ins[25:0], 2'b00};
            m_jrpc = r;
        end
`ifdef PC_NEXT_UNIT_EXC_EN
        if (exc) begin
            m_epc = m_pc;
            m_pc  = EXC_PC;
        end else if (er) begin
            m_pc = m_epc;
        end else if (rej) begin
            m_epc = m_pc;
            m_pc  = EXC_PC;
            m_mis = 1'b1;
        end else if (wr) begin
            m_pc = nxt;
        end
`else
        if (rej) m_mis = 1'b1;
        else if (wr) m_pc = nxt;
`endif
        push_model(tag);
        @(negedge clk);
        pop_check();
    endtask

    task automatic idle(input string tag);
        step(tag, 1'b0, 32'h0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        rst_n = 1'b0; tgt_ld = 1'b0; instr = '0; rpc = '0;
        pc_wr = 1'b0; pc_sel = 2'b00; br_taken = 1'b0;
`ifdef PC_NEXT_UNIT_EXC_EN
        exc_req = 1'b0; eret = 1'b0;
`endif
        model_reset();
        @(negedge clk);
        push_model("reset");
        pop_check();
        rst_n = 1'b1;
        idle("reset_release");

        // Branch with offset -1: target = pc+4-4 = pc.
        step("br_ld", 1'b1, 32'h0000_FFFF, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("br_target_const", bpc_q, 32'h0000_3000);
        step("br_taken", 1'b0, 32'h0, '0, 1'b1, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("br_taken_const", pc, 32'h0000_3000);
        step("br_not_taken", 1'b0, 32'h0, '0, 1'b1, 2'b01, 1'b0, 1'b0, 1'b0);
        chk("br_not_taken_const", pc, 32'h0000_3004);

        // Jump.
        step("j_ld", 1'b1, 32'h0000_0C10, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("j_commit", 1'b0, 32'h0, '0, 1'b1, 2'b10, 1'b1, 1'b0, 1'b0);
        chk("j_const", pc, 32'h0000_3040);

        // br_taken ignored when not selected or not writing.
        step("hold_no_wr", 1'b0, 32'h0, '0, 1'b0, 2'b01, 1'b1, 1'b0, 1'b0);
        chk("hold_const", pc, 32'h0000_3040);

        // Misaligned jr.
        step("jr_ld_bad", 1'b1, 32'h0000_0C10, 32'h0000_3002, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("jr_bad", 1'b0, 32'h0, '0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        chk("misalign_pulse_const", W'(misalign), W'(1));
`ifdef PC_NEXT_UNIT_EXC_EN
        chk("misalign_exc_pc_const", pc, 32'h0000_4180);
        chk("misalign_exc_epc_const", epc, 32'h0000_3040);
        step("eret_after_mis", 1'b0, 32'h0, '0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1);
`else
        chk("misalign_hold_const", pc, 32'h0000_3040);
        idle("mis_fall");
        chk("misalign_fall_const", W'(misalign), W'(0));
        step("jr_bad2", 1'b0, 32'h0, '0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
`endif
        // Legal commit right after a rejected one.
        step("seq_after_bad", 1'b0, 32'h0, '0, 1'b1, 2'b00, 1'b1, 1'b0, 1'b0);
        chk("seq_after_bad_const", pc, 32'h0000_3044);

        // Simultaneous load and commit: commit sees the old jpc_q.
        step("ld_and_commit", 1'b1, 32'h0000_0100, 32'h0000_3010, 1'b1, 2'b10, 1'b0, 1'b0, 1'b0);
        chk("ld_commit_pc_const", pc, 32'h0000_3040);
        chk("ld_commit_jpc_const", jpc_q, 32'h0000_0400);

        // Wraparound of pc_plus4.
        step("wrap_ld", 1'b1, 32'h0, 32'hFFFF_FFFC, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("wrap_jr", 1'b0, 32'h0, '0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        chk("wrap_plus4_const", pc_plus4, 32'h0000_0000);
        step("wrap_seq", 1'b0, 32'h0, '0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b0);
        chk("wrap_pc_const", pc, 32'h0000_0000);

`ifdef PC_NEXT_UNIT_EXC_EN
        // Exception entry and return.
        step("jr_ld_3010", 1'b1, 32'h0, 32'h0000_3010, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0);
        step("jr_3010", 1'b0, 32'h0, '0, 1'b1, 2'b11, 1'b0, 1'b0, 1'b0);
        step("exc", 1'b0, 32'h0, '0, 1'b1, 2'b00, 1'b0, 1'b1, 1'b1);
        chk("exc_pc_const", pc, 32'h0000_4180);
        chk("exc_epc_const", epc, 32'h0000_3010);
        step("eret", 1'b0, 32'h0, '0, 1'b1, 2'b00, 1'b0, 1'b0, 1'b1);
        chk("eret_pc_const", pc, 32'h0000_3010);
`endif

        // Pseudo-random steps against the model.
        for (int i = 0; i < 60; i++) begin
            logic [W-1:0] r;
            r = W'($urandom) & ~W'(3);
            if ($urandom_range(0, 3) == 0) r[1:0] = 2'($urandom_range(1, 3));
`ifdef PC_NEXT_UNIT_EXC_EN
            step("rand", 1'($urandom), $urandom, r, 1'($urandom), 2'($urandom),
                 1'($urandom), ($urandom_range(0, 7) == 0), ($urandom_range(0, 7) == 0));
`else
            step("rand", 1'($urandom), $urandom, r, 1'($urandom), 2'($urandom),
                 1'($urandom), 1'b0, 1'b0);
`endif
        end

        // Asynchronous reset asserted mid-cycle.
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        push_model("async_reset");
        pop_check();
        @(negedge clk);
        rst_n = 1'b1;
        idle("after_async_reset");

        if (sb.size() != 0) begin
            checks++;
            errors++;
            $error("FAIL scoreboard_leftover observed=%0d expected=0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
